// File: rtl/ws2812_pkg.sv
// Shared types and timing helpers for the WS2812 chain driver.
package ws2812_pkg;

    localparam int PIXEL_W = 24;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HIGH,
        LOW,
        LATCH
    } state_t;

    // 64-bit intermediate keeps f_clk*ns from overflowing at long latch times
    function automatic int ns_to_cyc(input longint f_clk, input longint ns);
        return int'((f_clk / 1000) * ns / 1_000_000);
    endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Simple dual-port pixel buffer: synchronous read, read returns old data
// on a same-address write; out-of-range writes are dropped.
module ws2812_pixel_ram
    import ws2812_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  pixel_t        wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output pixel_t        rd_data_o
);

    pixel_t mem_q [DEPTH];
    pixel_t rd_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i && int'(wr_addr_i) < DEPTH) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/ws2812_chain.sv
// WS2812 chain driver: buffered GRB pixels serialised MSB-first + latch gap.
// Optional WS2812_AUTO_REFRESH_EN: any buffer write requests a new frame.
module ws2812_chain
    import ws2812_pkg::*;
#(
    parameter int F_CLK    = 50_000_000,
    parameter int NUM_LEDS = 8,
    parameter int T0H_NS   = 400,
    parameter int T1H_NS   = 800,
    parameter int TBIT_NS  = 1250,
    parameter int RESET_US = 300,
    localparam int ADDR_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ws2812_dat
);

    localparam int T0H_CYC   = ns_to_cyc(F_CLK, T0H_NS);
    localparam int T1H_CYC   = ns_to_cyc(F_CLK, T1H_NS);
    localparam int TBIT_CYC  = ns_to_cyc(F_CLK, TBIT_NS);
    localparam int RESET_CYC = ns_to_cyc(F_CLK, RESET_US * 1000);
    localparam int CNT_MAX   = (RESET_CYC > TBIT_CYC) ? RESET_CYC : TBIT_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_LEDS - 1);

    if (T0H_CYC < 1 || T1H_CYC <= T0H_CYC || TBIT_CYC <= T1H_CYC) begin : g_bad
        $error("ws2812_chain: bit timing constants out of order");
    end

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        bit_q;
    logic [ADDR_W-1:0] pix_q;
    pixel_t            shift_q;
    logic              busy_q;
    logic              done_q;
    logic              dat_q;

    pixel_t            rd_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  hi_end;
    logic              bit_end;
    logic              last_bit;
    logic              last_pix;
    logic              go;

    assign hi_end   = shift_q[PIXEL_W-1] ? CNT_W'(T1H_CYC - 1)
                                         : CNT_W'(T0H_CYC - 1);
    assign bit_end  = (state_q == LOW) && (cnt_q == CNT_W'(TBIT_CYC - 1));
    assign last_bit = (bit_q == 5'd0);
    assign last_pix = (pix_q == LAST_PIX);

    // The RAM output register doubles as the next-pixel holding register:
    // it only updates in IDLE (pixel 0) and as bit 0 enters HIGH.
    assign rd_en   = (state_q == IDLE)
                   || (bit_end && bit_q == 5'd1 && !last_pix);
    assign rd_addr = (state_q == IDLE) ? '0 : pix_q + ADDR_W'(1);

    ws2812_pixel_ram #(
        .DEPTH (NUM_LEDS),
        .AW    (ADDR_W)
    ) u_ram (
        .clk_i     (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

`ifdef WS2812_AUTO_REFRESH_EN
    logic dirty_q;
    logic wr_ok;

    assign wr_ok = wr_en && (int'(wr_addr) < NUM_LEDS);
    assign go    = start || dirty_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dirty_q <= 1'b0;
        end else if (wr_ok) begin
            dirty_q <= 1'b1;
        end else if (state_q == IDLE && go) begin
            dirty_q <= 1'b0;
        end
    end
`else
    assign go = start;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            pix_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dat_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    shift_q <= rd_data;
                    bit_q   <= 5'd23;
                    pix_q   <= '0;
                    cnt_q   <= '0;
                    dat_q   <= 1'b1;
                    state_q <= HIGH;
                end
                HIGH: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == hi_end) begin
                        dat_q   <= 1'b0;
                        state_q <= LOW;
                    end
                end
                LOW: begin
                    if (!bit_end) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        if (!last_bit) begin
                            shift_q <= shift_q << 1;
                            bit_q   <= bit_q - 1'b1;
                            dat_q   <= 1'b1;
                            state_q <= HIGH;
                        end else if (!last_pix) begin
                            shift_q <= rd_data;
                            bit_q   <= 5'd23;
                            pix_q   <= pix_q + ADDR_W'(1);
                            dat_q   <= 1'b1;
                            state_q <= HIGH;
                        end else begin
                            state_q <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    if (cnt_q == CNT_W'(RESET_CYC - 1)) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ws2812_dat = dat_q;

endmodule

// File: tb/tb_ws2812_chain.sv
// Self-checking bench for ws2812_chain at 50 MHz with a 2-pixel chain.
module tb_ws2812_chain;

    localparam int N     = 2;
    localparam int TB    = 62;
    localparam int T0    = 20;
    localparam int T1    = 40;
    localparam int RST   = 15000;
    localparam int NB    = 24 * N;
    localparam int TDONE = 1 + NB * TB + RST;
`ifdef WS2812_AUTO_REFRESH_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        wr_en   = 1'b0;
    logic [0:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        start   = 1'b0;
    logic        busy;
    logic        done;
    logic        ws2812_dat;

    ws2812_chain #(
        .F_CLK    (50_000_000),
        .NUM_LEDS (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .ws2812_dat (ws2812_dat)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc   = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Model: frame time t counts cycles from the accepting edge.
    logic [23:0] mbuf [N];
    logic [23:0] mfr  [N];
    bit          m_act   = 1'b0;
    bit          m_dirty = 1'b0;
    int          m_t     = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_act   = 1'b0;
                m_t     = 0;
                m_dirty = 1'b0;
            end else if (m_act && m_t != TDONE) begin
                m_t++;
                for (int k = 0; k < N - 1; k++) begin
                    if (m_t == 1 + (24 * k + 23) * TB) mfr[k+1] = mbuf[k+1];
                end
            end else begin
                m_act = 1'b0;
                if (start || (AUTO && m_dirty)) begin
                    m_act   = 1'b1;
                    m_t     = 0;
                    mfr[0]  = mbuf[0];
                    m_dirty = 1'b0;
                end
            end
            if (wr_en && int'(wr_addr) < N) begin
                mbuf[wr_addr] = wr_data;
                if (!reset) m_dirty = 1'b1;
            end
        end
    end

    function automatic logic [2:0] expv();
        int b, ph, p, i;
        if (!m_act) return 3'b000;
        if (m_t == TDONE) return 3'b010;
        if (m_t >= 1 && m_t < 1 + NB * TB) begin
            b  = (m_t - 1) / TB;
            ph = (m_t - 1) % TB;
            p  = b / 24;
            i  = 23 - b % 24;
            return {2'b10, ph < (mfr[p][i] ? T1 : T0)};
        end
        return 3'b100;
    endfunction

    initial begin
        logic [2:0] e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e = expv();
            check("dat", ws2812_dat, e[0]);
            check("busy", busy, e[2]);
            check("done", done, e[1]);
        end
    end

    task automatic wr(input logic [0:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_until(input longint tgt);
        while (cyc < tgt) @(negedge clk);
    endtask

    task automatic wait_busy(output longint c0);
        for (int i = 0; i < 5 && !busy; i++) @(negedge clk);
        check("busy_seen", busy, 1);
        c0 = cyc;
    endtask

    task automatic wait_done(input longint c0, output longint cd);
        for (int i = 0; i < 20000 && !done; i++) @(negedge clk);
        check("done_seen", done, 1);
        check("frame_len", 32'(cyc - c0), TDONE);
        check("done_busy", busy, 0);
        cd = cyc;
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (ws2812_dat == lvl && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic decode(input longint c0, input int p,
                          output logic [23:0] v);
        for (int i = 0; i < 24; i++) begin
            wait_until(c0 + 1 + (24 * p + i) * TB + 30);
            v[23-i] = ws2812_dat;
        end
    endtask

    task automatic count_hi(input int cycles, output int nb, output int nd);
        nb = 0;
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            nb += int'(busy);
            nd += int'(done);
        end
    endtask

    initial begin
        longint      c_st, c_acc, c_d;
        int          n, nb, nd;
        logic [23:0] v;

        @(negedge clk);
        wr(1'b0, 24'hFF00AA);
        wr(1'b1, 24'h000001);
        repeat (3) @(negedge clk);
        check("rst_busy0", busy, 0);
        check("rst_dat0", ws2812_dat, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        start = 1'b1;
        c_st  = cyc;
        wait_busy(c_acc);
        check("start_lat", 32'(c_acc - c_st), 1);
        check("load_dat", ws2812_dat, 0);
        @(negedge clk);
        check("dat_rise", ws2812_dat, 1);
        run_len(1'b1, n);
        check("t1h_len", n, 40);
        run_len(1'b0, n);
        check("t1l_len", n, 22);
        wait_until(c_acc + 1 + 8 * TB);
        run_len(1'b1, n);
        check("t0h_len", n, 20);
        decode(c_acc, 1, v);
        check("f1_pix1", v, 24'h000001);
        wait_done(c_acc, c_d);

        @(negedge clk);
        check("restart", busy, 1);
        c_acc = cyc;
        start = 1'b0;
        @(negedge clk);
        check("restart_dat", ws2812_dat, 1);
        wait_until(c_acc + 1425);
        wr(1'b1, 24'h123456);
        wr(1'b1, 24'h654321);
        decode(c_acc, 1, v);
        check("f2_pix1", v, 24'h123456);
        wait_done(c_acc, c_d);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_busy(c_acc);
        wait_until(c_acc + 1 + 18 * TB + 30);
        check("pre_rst_dat", ws2812_dat, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_dat", ws2812_dat, 0);
        check("abort_busy", busy, 0);
        reset = 1'b0;
        count_hi(30, nb, nd);
        check("abort_nodone", nd, 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_busy(c_acc);
        wait_until(c_acc + 1000);
        wr(1'b0, 24'h00FF00);
        decode(c_acc, 1, v);
        check("f4_pix1", v, 24'h654321);
        wait_done(c_acc, c_d);

`ifdef WS2812_AUTO_REFRESH_EN
        @(negedge clk);
        check("auto_follow", busy, 1);
        c_acc = cyc;
        decode(c_acc, 0, v);
        check("f5_pix0", v, 24'h00FF00);
        wait_done(c_acc, c_d);
        count_hi(50, nb, nd);
        check("one_follow", nb, 0);
        wr(1'b1, 24'hABCDEF);
        check("auto_idle0", busy, 0);
        @(negedge clk);
        check("auto_idle1", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`else
        count_hi(50, nb, nd);
        check("no_follow", nb, 0);
        wr(1'b1, 24'hABCDEF);
        count_hi(50, nb, nd);
        check("no_auto", nb, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
